// File: rtl/your_multiplier_module_here_if.sv
// rtl/your_multiplier_module_here_if.sv - operand/product bundle for the 4x4 approximate multiplier
interface your_multiplier_module_here_if;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] result;

  modport master (output A, output B, input result);
  modport slave  (input A, input B, output result);
endinterface

// File: rtl/your_multiplier_module_here.sv
// rtl/your_multiplier_module_here.sv - registered 4x4 multiplier; APPROX_LSB_EN selects OR-compressed low columns
module your_multiplier_module_here (
  input  logic                         clk,
  input  logic                         rst,
  your_multiplier_module_here_if.slave bus
);

  logic [7:0] product;

`ifdef APPROX_LSB_EN
  logic [2:0] low_or;
  logic [7:0] high_sum;

  // Columns 0..2 collapse to an OR with no carry out; the rest accumulate exactly.
  always_comb begin
    low_or   = '0;
    high_sum = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (i + j < 3) begin
          low_or[i+j] = low_or[i+j] | (bus.A[i] & bus.B[j]);
        end else begin
          high_sum = high_sum + ({7'd0, bus.A[i] & bus.B[j]} << (i + j));
        end
      end
    end
  end

  // high_sum is a multiple of 8, so the low bits simply concatenate.
  assign product = {high_sum[7:3], low_or};
`else
  assign product = {4'd0, bus.A} * {4'd0, bus.B};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.result <= 8'd0;
    end else begin
      bus.result <= product;
    end
  end

endmodule

// File: tb/tb_your_multiplier_module_here.sv
// tb/tb_your_multiplier_module_here.sv - self-checking bench for the 4x4 approximate multiplier
module tb_your_multiplier_module_here;

`ifdef APPROX_LSB_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  logic [7:0] exp_r = 8'd0;
  logic [7:0] res_tab [256];

  your_multiplier_module_here_if bus ();

  your_multiplier_module_here dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Column-count model: start from the exact product, remove the true weight of
  // the low three columns and put back one bit per non-empty column.
  function automatic int model(input int a, input int b);
    int cnt [7];
    int lowsum;
    int r;
    if (!APPROX) return a * b;
    for (int k = 0; k < 7; k++) cnt[k] = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        cnt[i+j] += (a[i] & b[j]);
    lowsum = cnt[0] + 2 * cnt[1] + 4 * cnt[2];
    r = (cnt[0] > 0 ? 1 : 0) + (cnt[1] > 0 ? 2 : 0) + (cnt[2] > 0 ? 4 : 0);
    return a * b - lowsum + r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic apply_check(input int a, input int b, input int ap, input int ex, input string name);
    bus.A = 4'(a);
    bus.B = 4'(b);
    @(posedge clk);
    #1;
    check(name, int'(bus.result), APPROX ? ap : ex);
  endtask

  always @(posedge clk) exp_r = rst ? 8'd0 : 8'(model(int'(bus.A), int'(bus.B)));
  always @(posedge rst) exp_r = 8'd0;

  always @(negedge clk) begin
    if (chk_en) check("cycle_compare", int'(bus.result), rst ? 0 : int'(exp_r));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.A = 4'd15;
    bus.B = 4'd15;
    #1 rst = 1'b1;
    #1 check("reset_state", int'(bus.result), 0);

    check("model_3x3", model(3, 3), APPROX ? 7 : 9);
    check("model_5x5", model(5, 5), APPROX ? 21 : 25);
    check("model_15x15", model(15, 15), APPROX ? 215 : 225);

    @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1 check("post_reset_15x15", int'(bus.result), APPROX ? 215 : 225);

    // Asynchronous reset with no clock edge in between
    rst = 1'b1;
    #1 check("async_reset", int'(bus.result), 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("release_15x15", int'(bus.result), APPROX ? 215 : 225);

    apply_check(2, 3, 6, 6, "exact_2x3");
    apply_check(1, 1, 1, 1, "exact_1x1");
    apply_check(4, 4, 16, 16, "exact_4x4");
    apply_check(0, 13, 0, 0, "zero_0x13");
    apply_check(3, 3, 7, 9, "approx_3x3");
    apply_check(5, 5, 21, 25, "approx_5x5");
    apply_check(15, 15, 215, 225, "approx_15x15");
    apply_check(7, 1, 7, 7, "approx_7x1");

    apply_check(3, 3, 7, 9, "b2b_3x3");
    apply_check(2, 3, 6, 6, "b2b_2x3");
    apply_check(15, 15, 215, 225, "b2b_15x15");

    // Operand change between edges must not reach result
    bus.A = 4'd1;
    bus.B = 4'd2;
    #2 check("no_comb_path", int'(bus.result), APPROX ? 215 : 225);

    // Mid-stream reset pulse, then stream resumes
    apply_check(5, 5, 21, 25, "stream_5x5");
    bus.A = 4'd3;
    bus.B = 4'd3;
    rst = 1'b1;
    #1 check("midstream_reset", int'(bus.result), 0);
    #1 rst = 1'b0;
    bus.A = 4'd2;
    bus.B = 4'd3;
    @(posedge clk);
    #1 check("resume_2x3", int'(bus.result), 6);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        bus.A = 4'(a);
        bus.B = 4'(b);
        @(posedge clk);
        #1 res_tab[a*16+b] = bus.result;
      end
    end
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        checks++;
        if (int'(res_tab[a*16+b]) > a * b) begin
          errors++;
          $display("FAIL sweep_le a=%0d b=%0d: got %0d, expected <= %0d", a, b, res_tab[a*16+b], a * b);
        end
        if (a < b) check($sformatf("sweep_sym a=%0d b=%0d", a, b),
                         int'(res_tab[a*16+b]), int'(res_tab[b*16+a]));
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
